// File: rtl/bcd_serial_sub.sv
// ---------------------------------------------------------------------------
// bcd_serial_sub
// Digit-serial BCD subtractor: diff = a - b - bin over NDIGITS packed BCD
// digits, one digit per clock. Digit i is at bits [4*i+3:4*i], digit 0 is
// least significant. One start/done transaction per operation.
// The result is ten's-complement: when bout=1, diff = 10^NDIGITS + a - b - bin.
//
// Optional feature macro: BCD_SUB_DIGIT_CHECK_EN
//   defined   -> invalid is set (sticky per operation) when any processed
//                operand digit exceeds 9
//   undefined -> invalid is constant 0
//
// Ports:
//   clk       in   clock, rising edge
//   areset_n  in   asynchronous active-low reset
//   start     in   request, sampled in IDLE only
//   a, b      in   4*NDIGITS packed BCD minuend / subtrahend
//   bin       in   borrow-in, sampled with start
//   busy      out  high while digits are being processed
//   done      out  one-cycle pulse, result valid from here on
//   diff      out  4*NDIGITS packed BCD difference
//   bout      out  borrow-out of the most significant digit
//   invalid   out  non-BCD operand digit seen (feature macro only)
// ---------------------------------------------------------------------------
module bcd_serial_sub #(
    parameter int NDIGITS = 100
) (
    input  logic                   clk,
    input  logic                   areset_n,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   a,
    input  logic [4*NDIGITS-1:0]   b,
    input  logic                   bin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NDIGITS-1:0]   diff,
    output logic                   bout,
    output logic                   invalid
);

    localparam int W     = 4 * NDIGITS;
    localparam int CNT_W = $clog2(NDIGITS);

    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NDIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;
    logic [W-1:0]     r_diff;
    logic             r_bout;
    logic [4:0]       w_step;

    // One decimal digit of subtraction: returns {borrow_out, digit}.
    // t spans -16..15, so 6 bits signed are enough; a negative t is
    // corrected by +10 and only the low nibble is kept.
    function automatic logic [4:0] digit_sub(input logic [3:0] x,
                                             input logic [3:0] y,
                                             input logic       bi);
        logic [5:0] t;
        t = {2'b00, x} - {2'b00, y} - {5'b00000, bi};
        if (t[5]) begin
            digit_sub = {1'b1, t[3:0] + 4'd10};
        end else begin
            digit_sub = {1'b0, t[3:0]};
        end
    endfunction

    // Digit currently being processed. Operands shift right each RUN
    // cycle, so the active digit is always the bottom nibble.
    always_comb begin
        w_step = digit_sub(r_a[3:0], r_b[3:0], r_borrow);
    end

    // Control FSM, operand shift registers and result accumulation.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                        r_diff   <= '0;
                        r_bout   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a      <= {4'b0000, r_a[W-1:4]};
                    r_b      <= {4'b0000, r_b[W-1:4]};
                    // New digits enter at the top; after NDIGITS shifts
                    // digit 0 has reached the bottom nibble.
                    r_diff   <= {w_step[3:0], r_diff[W-1:4]};
                    r_borrow <= w_step[4];
                    if (r_cnt == LAST_DIGIT) begin
                        r_bout  <= w_step[4];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BCD_SUB_DIGIT_CHECK_EN
    logic r_invalid;

    // A nibble above 9 is not a BCD digit.
    function automatic logic non_bcd(input logic [3:0] d);
        non_bcd = (d > 4'd9);
    endfunction

    // Sticky invalid flag: cleared on accept, set by any processed bad digit.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_invalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_invalid <= 1'b0;
                    end else begin
                        r_invalid <= r_invalid;
                    end
                end
                S_RUN: begin
                    if (non_bcd(r_a[3:0]) || non_bcd(r_b[3:0])) begin
                        r_invalid <= 1'b1;
                    end else begin
                        r_invalid <= r_invalid;
                    end
                end
                default: begin
                    r_invalid <= r_invalid;
                end
            endcase
        end
    end

    assign invalid = r_invalid;
`else
    assign invalid = 1'b0;
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule

// File: tb/tb_bcd_serial_sub.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_sub
// Directed bench for bcd_serial_sub (NDIGITS=100). A cycle-level model
// computes the expected result by nine's-complement addition
// (a + (99..9 - b) + !bin, bout = no carry out) and a compare process checks
// busy/done every cycle and diff/bout/invalid whenever no operation is in
// flight. Directed tasks add literal expectations for the listed scenarios.
// ---------------------------------------------------------------------------
module tb_bcd_serial_sub;

    localparam int N   = 100;
    localparam int W   = 4 * N;
    localparam int LIM = 400;

`ifdef BCD_SUB_DIGIT_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef logic [W:0] wide_t;

    logic         clk;
    logic         areset_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         invalid;

    int n_checks;
    int n_pass;

    bcd_serial_sub #(.NDIGITS(N)) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .bout     (bout),
        .invalid  (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input wide_t act, input wide_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Nine's-complement model: returns {bout, diff}.
    function automatic wide_t model_sub(input logic [W-1:0] x,
                                        input logic [W-1:0] y,
                                        input logic bi);
        wide_t r;
        int carry;
        int s;
        r = '0;
        carry = bi ? 0 : 1;
        for (int i = 0; i < N; i++) begin
            s = int'(x[4*i +: 4]) + (9 - int'(y[4*i +: 4])) + carry;
            if (s > 9) begin
                s = s - 10;
                carry = 1;
            end else begin
                carry = 0;
            end
            r[4*i +: 4] = 4'(s);
        end
        r[W] = (carry == 0);
        return r;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] x);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (x[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // ---------------- model ----------------
    int           m_left;
    logic         m_done;
    logic [W-1:0] m_diff;
    logic         m_bout;
    logic         m_inv;
    logic         m_chk;
    wide_t        p_res;
    logic         p_bad;

    always @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_diff <= '0;
            m_bout <= 1'b0;
            m_inv  <= 1'b0;
            m_chk  <= 1'b1;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0 && !m_done && start) begin
                m_left <= N;
                p_res  <= model_sub(a, b, bin);
                p_bad  <= has_bad(a) || has_bad(b);
            end else if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_diff <= p_res[W-1:0];
                    m_bout <= p_res[W];
                    m_inv  <= CHK_EN & p_bad;
                    m_chk  <= !p_bad;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        chk("busy", wide_t'(busy), wide_t'(m_left != 0));
        chk("done", wide_t'(done), wide_t'(m_done));
        if (busy && done) chk("busy_and_done", 2, 0);
        if (m_left == 0) begin
            chk("invalid", wide_t'(invalid), wide_t'(m_inv));
            if (m_chk) begin
                chk("diff", wide_t'(diff), wide_t'(m_diff));
                chk("bout", wide_t'(bout), wide_t'(m_bout));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin);
        @(negedge clk);
        a = xa; b = xb; bin = xbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done; cyc=1 at the first negedge after accept.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < LIM) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", wide_t'(done), 1);
    endtask

    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] nines;
    int           cyc;
    int           extra;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        areset_n = 1'b0;
        start    = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        nines = {N{4'h9}};
        repeat (3) @(negedge clk);
        chk("rst_outputs", wide_t'({busy, done, bout, invalid}), 0);
        chk("rst_diff", wide_t'(diff), 0);
        areset_n = 1'b1;

        // 42 - 17 = 25, latency check
        va = '0; va[15:0] = 16'h0042;
        vb = '0; vb[15:0] = 16'h0017;
        issue(va, vb, 1'b0);
        wait_done(cyc);
        chk("latency", wide_t'(cyc), 101);
        chk("op1_low", wide_t'(diff[15:0]), wide_t'(16'h0025));
        chk("op1_upper", wide_t'(diff[W-1:16]), 0);
        chk("op1_bout", wide_t'(bout), 0);

        // 0 - 1 wraps to all nines
        va = '0; vb = '0; vb[3:0] = 4'h1;
        issue(va, vb, 1'b0);
        wait_done(cyc);
        chk("wrap_diff", wide_t'(diff), wide_t'(nines));
        chk("wrap_bout", wide_t'(bout), 1);

        // all 9s - all 9s - 1, then with bin=0
        issue(nines, nines, 1'b1);
        wait_done(cyc);
        chk("n9_bin1_diff", wide_t'(diff), wide_t'(nines));
        chk("n9_bin1_bout", wide_t'(bout), 1);
        issue(nines, nines, 1'b0);
        wait_done(cyc);
        chk("n9_bin0_diff", wide_t'(diff), 0);
        chk("n9_bin0_bout", wide_t'(bout), 0);

        // start ignored during RUN and DONE: 500 - 123 = 377
        va = '0; va[15:0] = 16'h0500;
        vb = '0; vb[15:0] = 16'h0123;
        issue(va, vb, 1'b0);
        repeat (9) @(negedge clk);
        a = '0; a[15:0] = 16'h0999; b = '0; b[3:0] = 4'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        a = '0; a[15:0] = 16'h0888; start = 1'b1;
        chk("ign_diff", wide_t'(diff), wide_t'(16'h0377));
        chk("ign_bout", wide_t'(bout), 0);
        @(negedge clk);
        start = 1'b0;
        extra = 0;
        repeat (110) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("no_second_done", wide_t'(extra), 0);
        chk("hold_diff", wide_t'(diff), wide_t'(16'h0377));

        // asynchronous reset in the middle of RUN
        va = '0; va[15:0] = 16'h0777;
        vb = '0; vb[15:0] = 16'h0111;
        issue(va, vb, 1'b0);
        repeat (49) @(negedge clk);
        areset_n = 1'b0;
        #1;
        chk("midrst_flags", wide_t'({busy, done, bout, invalid}), 0);
        chk("midrst_diff", wide_t'(diff), 0);
        @(negedge clk);
        areset_n = 1'b1;
        va = '0; va[15:0] = 16'h0100;
        vb = '0; vb[15:0] = 16'h0001;
        issue(va, vb, 1'b0);
        wait_done(cyc);
        chk("post_rst_latency", wide_t'(cyc), 101);
        chk("post_rst_diff", wide_t'(diff), wide_t'(16'h0099));
        chk("post_rst_bout", wide_t'(bout), 0);

        // non-BCD digit, then a clean operation
        va = '0; va[3:0] = 4'hA;
        vb = '0;
        issue(va, vb, 1'b0);
        wait_done(cyc);
        chk("invalid_set", wide_t'(invalid), wide_t'(CHK_EN));
        va = '0; va[3:0] = 4'h5;
        vb = '0; vb[3:0] = 4'h3;
        issue(va, vb, 1'b0);
        wait_done(cyc);
        chk("invalid_clr", wide_t'(invalid), 0);
        chk("clean_diff", wide_t'(diff), wide_t'(4'h2));

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
